multicycle_ctrl_hs: RTL and testbench
=====================================

# multicycle_ctrl_hs

Parametrised multicycle controller for the 16-bit datapath. It adds a ready/valid memory handshake with wait states, a memory-timeout fault, and halt/run control on top of the fixed five-cycle FETCH/DECODE/EXECUTE/op/WRITE sequence. It sits between the instruction/data memory port and the datapath muxes, ALU, register file and PC.

## Interface
Parameters:
- WIDTH, 16, datapath and PSR width
- ALU_CONT_BITS, 6, ALU control width (≥6)
- REG_BITS, 4, register index width (≥4)
- TIMEOUT, 15, maximum wait cycles for mem_ready before fault (1..255)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- op_code  in  4  instruction bits [15:12]
- ext_op_code  in  4  instruction bits [7:4]
- A_index  in  REG_BITS  Rdest/condition field
- psr_flags  in  WIDTH  C=[0], L=[2], F=[5], Z=[6], N=[7]
- mem_ready  in  1  memory completed current request this cycle
- run  in  1  0 holds the controller in FETCH (no request issued)
- halt_req  in  1  enter HALT at next instruction boundary
- alu_A_src, alu_B_src  out  1  ALU operand muxes (B: 1 = immediate)
- alu_cont  out  ALU_CONT_BITS  ALU operation
- reg_write  out  1  register-file write enable
- reg_write_src  out  2  0 ALU, 1 memory, 2 PC+1
- pc_src  out  2  0 PC+ALU (branch), 1 Rsrc (jump), 2 PC+1
- pc_en  out  1  PC update enable
- instruction_en  out  1  instruction register load
- mem_req  out  1  memory request
- mem_we  out  1  write (with mem_req)
- mem_data_sel  out  1  0 PC address, 1 Rsrc address
- halted  out  1  in HALT
- fault  out  1  memory timeout; sticky until reset

## Operation
- Moore outputs decoded from state; all outputs 0 unless listed. Reset: state FETCH, wait counter 0, cond_taken 0, fault 0, all outputs 0.
- FETCH: if run=1, mem_req=1, mem_data_sel=0. mem_ready=1 -> DECODE, else stay. If run=0, stay with no request.
- DECODE: instruction_en=1 -> EXECUTE.
- EXECUTE: latch cond_taken = cond[A_index]. Next state:
  - op 1111 -> LUI
  - op 0000 or op[1:0]≠0 -> ALU
  - op 1100 -> WRITE (branch)
  - op 0100 ext 0000 -> LOAD; ext 0100 -> STORE; ext 1000 -> JAL; ext 1100 -> WRITE (jcond)
  - op 1000 ext 0100 -> LSH
  - any other -> WRITE (treated as NOP)
- Conditions: 0 Z, 1 !Z, 2 C, 3 !C, 4 L, 5 !L, 6 N, 7 !N, 8 F, 9 !F, 10 !L&!Z, 11 L|Z, 12 !N&!Z, 13 N|Z, 14 always, 15 never.
- ALU: alu_A_src=1; alu_B_src=imm; alu_cont={00, imm?op:ext}; reg_write=1 unless compare (op=1011 or op=0000 with ext=1011) -> WRITE.
- LSH: alu_cont={10,op} -> WRITE. LUI: A_src=B_src=1, alu_cont={11,op}, reg_write=1 -> WRITE.
- LOAD: mem_req=1, mem_data_sel=1; on mem_ready -> LOAD_WB (reg_write=1, reg_write_src=1) -> WRITE.
- STORE: mem_req=mem_we=1, mem_data_sel=1; on mem_ready -> WRITE.
- JAL: reg_write=1, reg_write_src=2 -> WRITE.
- WRITE: pc_en=1. pc_src: JAL 1; jcond cond_taken?1:2; branch: B_src=1, alu_cont={11,op}, cond_taken?0:2; otherwise 2. Next: halt_req ? HALT : FETCH.
- HALT: halted=1; leave to FETCH when halt_req=0.
- Timeout: counter clears on entering any wait-capable state (FETCH with run=1, LOAD, STORE) and increments each cycle with mem_req=1 and mem_ready=0. When it reaches TIMEOUT -> FAULT (fault=1, all else 0) until reset.

## Timing
- Zero-wait ALU instruction: 5 cycles FETCH->WRITE; LOAD 6; each mem wait cycle adds 1.
- mem_ready sampled only while mem_req=1; ignored otherwise.
- cond_taken uses psr_flags as of the EXECUTE cycle; later flag changes are ignored.
- halt_req sampled only in WRITE; run sampled only in FETCH.
- Reset low in any state, including mid-wait or FAULT: FETCH next edge, outputs 0 that cycle.
- mem_ready in the same cycle the counter hits TIMEOUT: ready wins, no fault.

## Test plan
- Reset, run=1, mem_ready=1, op=0000 ext=0101: states FETCH,DECODE,EXECUTE,ALU,WRITE; reg_write only in ALU; alu_cont=000101; pc_src=2 with pc_en in cycle 5.
- LOAD with mem_ready low 3 cycles in LOAD: 9 cycles total; LOAD_WB reg_write_src=1; mem_req held 4 cycles.
- Branch op=1100, A_index=0, Z=1 -> pc_src=0, alu_cont=111100; Z=0 -> pc_src=2. Jcond A_index=15 -> pc_src=2.
- TIMEOUT=3, mem_ready never asserted in FETCH: fault=1 after 3 wait cycles, stays through 20 cycles; reset low clears it.
- Compare op=1011: ALU state with reg_write=0. halt_req=1 in WRITE: halted=1 until halt_req=0, then FETCH.
- run=0 for 4 cycles: no mem_req, no timeout progress; run=1 -> normal fetch.

Source files
------------

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle controller for the 16-bit datapath: FETCH/DECODE/EXECUTE/op/WRITE
// sequencing with a ready/valid memory handshake, wait timeout fault and halt/run control.
module multicycle_ctrl_hs #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6,
    parameter int REG_BITS      = 4,
    parameter int TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               op_code,
    input  logic [3:0]               ext_op_code,
    input  logic [REG_BITS-1:0]      A_index,
    input  logic [WIDTH-1:0]         psr_flags,
    input  logic                     mem_ready,
    input  logic                     run,
    input  logic                     halt_req,
    output logic                     alu_A_src,
    output logic                     alu_B_src,
    output logic [ALU_CONT_BITS-1:0] alu_cont,
    output logic                     reg_write,
    output logic [1:0]               reg_write_src,
    output logic [1:0]               pc_src,
    output logic                     pc_en,
    output logic                     instruction_en,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     mem_data_sel,
    output logic                     halted,
    output logic                     fault
);

    // state    | meaning
    // FETCH    | request instruction (when run=1); DECODE | load IR; EXECUTE | classify, latch cond
    // ALU/LSH/LUI/JAL | single-cycle datapath op; LOAD/STORE | data access; LOAD_WB | write loaded data
    // WRITE    | PC update, halt boundary; HALT | parked; FAULT | memory timeout, sticky until reset
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_ALU, S_LSH, S_LUI, S_LOAD,
        S_LOAD_WB, S_STORE, S_JAL, S_WRITE, S_HALT, S_FAULT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic [7:0] wait_cnt;
    logic       cond_taken, cond_now;
    logic       flag_c, flag_l, flag_f, flag_z, flag_n;
    logic [3:0] cond_sel;
    logic       is_imm, is_cmp, is_jal, is_jcond, is_branch;
    logic       req_state, waiting, timeout_hit;
    logic       unused_psr;

    assign flag_c     = psr_flags[0];
    assign flag_l     = psr_flags[2];
    assign flag_f     = psr_flags[5];
    assign flag_z     = psr_flags[6];
    assign flag_n     = psr_flags[7];
    assign unused_psr = ^{psr_flags[WIDTH-1:8], psr_flags[4:3], psr_flags[1]};
    assign cond_sel   = 4'(A_index);

    assign is_imm    = (op_code != 4'b0000);
    assign is_cmp    = (op_code == 4'b1011) || (op_code == 4'b0000 && ext_op_code == 4'b1011);
    assign is_jal    = (op_code == 4'b0100) && (ext_op_code == 4'b1000);
    assign is_jcond  = (op_code == 4'b0100) && (ext_op_code == 4'b1100);
    assign is_branch = (op_code == 4'b1100);

    always_comb begin
        case (cond_sel)
            4'd0:    cond_now = flag_z;
            4'd1:    cond_now = !flag_z;
            4'd2:    cond_now = flag_c;
            4'd3:    cond_now = !flag_c;
            4'd4:    cond_now = flag_l;
            4'd5:    cond_now = !flag_l;
            4'd6:    cond_now = flag_n;
            4'd7:    cond_now = !flag_n;
            4'd8:    cond_now = flag_f;
            4'd9:    cond_now = !flag_f;
            4'd10:   cond_now = !flag_l && !flag_z;
            4'd11:   cond_now = flag_l || flag_z;
            4'd12:   cond_now = !flag_n && !flag_z;
            4'd13:   cond_now = flag_n || flag_z;
            4'd14:   cond_now = 1'b1;
            default: cond_now = 1'b0;
        endcase
    end

    // A ready in the cycle the count would expire still completes the access.
    assign req_state   = (state == S_FETCH && run) || state == S_LOAD || state == S_STORE;
    assign waiting     = req_state && !mem_ready;
    assign timeout_hit = waiting && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            cond_taken <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == S_EXECUTE)
                cond_taken <= cond_now;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:   if (run && mem_ready) state_nx = S_DECODE;
            S_DECODE:  state_nx = S_EXECUTE;
            S_EXECUTE: begin
                if (op_code == 4'b1111)
                    state_nx = S_LUI;
                else if (op_code == 4'b0000 || op_code[1:0] != 2'b00)
                    state_nx = S_ALU;
                else if (op_code == 4'b1100)
                    state_nx = S_WRITE;
                else if (op_code == 4'b0100) begin
                    case (ext_op_code)
                        4'b0000: state_nx = S_LOAD;
                        4'b0100: state_nx = S_STORE;
                        4'b1000: state_nx = S_JAL;
                        default: state_nx = S_WRITE;
                    endcase
                end else if (op_code == 4'b1000 && ext_op_code == 4'b0100)
                    state_nx = S_LSH;
                else
                    state_nx = S_WRITE;
            end
            S_ALU, S_LSH, S_LUI, S_LOAD_WB, S_JAL: state_nx = S_WRITE;
            S_LOAD:    if (mem_ready) state_nx = S_LOAD_WB;
            S_STORE:   if (mem_ready) state_nx = S_WRITE;
            S_WRITE:   state_nx = halt_req ? S_HALT : S_FETCH;
            S_HALT:    if (!halt_req) state_nx = S_FETCH;
            S_FAULT:   state_nx = S_FAULT;
            default:   state_nx = S_FETCH;
        endcase
        if (timeout_hit)
            state_nx = S_FAULT;
    end

    // Outputs are forced low while reset is asserted, whatever the current state.
    always_comb begin
        alu_A_src      = 1'b0;
        alu_B_src      = 1'b0;
        alu_cont       = '0;
        reg_write      = 1'b0;
        reg_write_src  = 2'd0;
        pc_src         = 2'd0;
        pc_en          = 1'b0;
        instruction_en = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_data_sel   = 1'b0;
        halted         = 1'b0;
        fault          = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH:   mem_req = run;
                S_DECODE:  instruction_en = 1'b1;
                S_ALU: begin
                    alu_A_src = 1'b1;
                    alu_B_src = is_imm;
                    alu_cont  = ALU_CONT_BITS'({2'b00, is_imm ? op_code : ext_op_code});
                    reg_write = !is_cmp;
                end
                S_LSH:     alu_cont = ALU_CONT_BITS'({2'b10, op_code});
                S_LUI: begin
                    alu_A_src = 1'b1;
                    alu_B_src = 1'b1;
                    alu_cont  = ALU_CONT_BITS'({2'b11, op_code});
                    reg_write = 1'b1;
                end
                S_LOAD: begin
                    mem_req      = 1'b1;
                    mem_data_sel = 1'b1;
                end
                S_LOAD_WB: begin
                    reg_write     = 1'b1;
                    reg_write_src = 2'd1;
                end
                S_STORE: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_data_sel = 1'b1;
                end
                S_JAL: begin
                    reg_write     = 1'b1;
                    reg_write_src = 2'd2;
                end
                S_WRITE: begin
                    pc_en = 1'b1;
                    if (is_jal)
                        pc_src = 2'd1;
                    else if (is_jcond)
                        pc_src = cond_taken ? 2'd1 : 2'd2;
                    else if (is_branch) begin
                        alu_B_src = 1'b1;
                        alu_cont  = ALU_CONT_BITS'({2'b11, op_code});
                        pc_src    = cond_taken ? 2'd0 : 2'd2;
                    end else
                        pc_src = 2'd2;
                end
                S_HALT:    halted = 1'b1;
                S_FAULT:   fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Randomized bench for multicycle_ctrl_hs: per-instruction output traces from a
// behavioural model, plus a TIMEOUT=3 instance for fault and run-hold behaviour.
module tb_multicycle_ctrl_hs;

    typedef struct packed {
        logic       a_src;
        logic       b_src;
        logic [5:0] cont;
        logic       rw;
        logic [1:0] rws;
        logic [1:0] pcs;
        logic       pce;
        logic       ien;
        logic       mreq;
        logic       mwe;
        logic       mds;
        logic       hlt;
        logic       flt;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        run;
        logic        mr;
        logic        hr;
        logic [3:0]  op;
        logic [3:0]  ext;
        logic [3:0]  aidx;
        logic [15:0] psr;
        out_t        exp;
    } cyc_t;

    localparam int K_ALU = 0, K_CMP = 1, K_LSH = 2, K_LUI = 3, K_LOAD = 4;
    localparam int K_STORE = 5, K_JAL = 6, K_JCOND = 7, K_BR = 8, K_NOP = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0, run = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
    logic [3:0]  op_code = '0, ext_op_code = '0, A_index = '0;
    logic [15:0] psr_flags = '0;
    logic        alu_A_src, alu_B_src, reg_write, pc_en, instruction_en;
    logic        mem_req, mem_we, mem_data_sel, halted, fault;
    logic [5:0]  alu_cont;
    logic [1:0]  reg_write_src, pc_src;

    logic        rst_to = 1'b0, run_to = 1'b0, mr_to = 1'b0;
    logic        a_src_t, b_src_t, rw_t, pce_t, ien_t, mreq_t, mwe_t, mds_t, hlt_t, flt_t;
    logic [5:0]  cont_t;
    logic [1:0]  rws_t, pcs_t;

    int   n_checks = 0;
    int   n_fail = 0;
    cyc_t plan[$];
    out_t obs_to;

    multicycle_ctrl_hs dut (
        .clk(clk), .reset(reset), .op_code(op_code), .ext_op_code(ext_op_code),
        .A_index(A_index), .psr_flags(psr_flags), .mem_ready(mem_ready), .run(run),
        .halt_req(halt_req), .alu_A_src(alu_A_src), .alu_B_src(alu_B_src),
        .alu_cont(alu_cont), .reg_write(reg_write), .reg_write_src(reg_write_src),
        .pc_src(pc_src), .pc_en(pc_en), .instruction_en(instruction_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_data_sel(mem_data_sel),
        .halted(halted), .fault(fault)
    );

    multicycle_ctrl_hs #(.TIMEOUT(3)) dut_to (
        .clk(clk), .reset(rst_to), .op_code(op_code), .ext_op_code(ext_op_code),
        .A_index(A_index), .psr_flags(psr_flags), .mem_ready(mr_to), .run(run_to),
        .halt_req(halt_req), .alu_A_src(a_src_t), .alu_B_src(b_src_t),
        .alu_cont(cont_t), .reg_write(rw_t), .reg_write_src(rws_t),
        .pc_src(pcs_t), .pc_en(pce_t), .instruction_en(ien_t),
        .mem_req(mreq_t), .mem_we(mwe_t), .mem_data_sel(mds_t),
        .halted(hlt_t), .fault(flt_t)
    );

    function automatic bit cond_true(input logic [3:0] sel, input logic [15:0] f);
        logic [4:0] fv;
        fv = {f[5], f[7], f[2], f[0], f[6]};
        if (sel < 4'd10) return fv[sel[3:1]] ^ sel[0];
        case (sel)
            4'd10:   return !f[2] && !f[6];
            4'd11:   return f[2] || f[6];
            4'd12:   return !f[7] && !f[6];
            4'd13:   return f[7] || f[6];
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int kind_of(input logic [3:0] op, input logic [3:0] ext);
        if (op == 4'd15) return K_LUI;
        if (op == 4'd0 || op[1:0] != 2'd0)
            return (op == 4'd11 || (op == 4'd0 && ext == 4'd11)) ? K_CMP : K_ALU;
        if (op == 4'd12) return K_BR;
        if (op == 4'd4) begin
            case (ext)
                4'd0:    return K_LOAD;
                4'd4:    return K_STORE;
                4'd8:    return K_JAL;
                4'd12:   return K_JCOND;
                default: return K_NOP;
            endcase
        end
        if (op == 4'd8 && ext == 4'd4) return K_LSH;
        return K_NOP;
    endfunction

    function automatic void rnd(inout cyc_t c);
        c.rst = 1'b1;
        c.run = 1'($urandom);
        c.mr  = 1'($urandom);
        c.hr  = 1'($urandom);
        c.psr = 16'($urandom);
        c.exp = '0;
    endfunction

    // Expected per-cycle trace of one instruction, from FETCH to the last HALT cycle.
    function automatic void add_instr(input logic [3:0] op, input logic [3:0] ext,
                                      input logic [3:0] aidx, input logic [15:0] px,
                                      input int nrun0, input int fwait, input int mwait,
                                      input int nhalt);
        cyc_t c;
        int   k;
        bit   taken, imm;
        k = kind_of(op, ext);
        taken = cond_true(aidx, px);
        imm = (op != 4'd0);
        c = '0;
        c.op = op; c.ext = ext; c.aidx = aidx;
        for (int i = 0; i < nrun0; i++) begin
            rnd(c); c.run = 1'b0; plan.push_back(c);
        end
        for (int i = 0; i <= fwait; i++) begin
            rnd(c); c.run = 1'b1; c.mr = (i == fwait); c.exp.mreq = 1'b1; plan.push_back(c);
        end
        rnd(c); c.exp.ien = 1'b1; plan.push_back(c);
        rnd(c); c.psr = px; plan.push_back(c);
        case (k)
            K_ALU, K_CMP: begin
                rnd(c); c.exp.a_src = 1'b1; c.exp.b_src = imm;
                c.exp.cont = {2'b00, imm ? op : ext}; c.exp.rw = (k == K_ALU);
                plan.push_back(c);
            end
            K_LSH: begin
                rnd(c); c.exp.cont = {2'b10, op}; plan.push_back(c);
            end
            K_LUI: begin
                rnd(c); c.exp.a_src = 1'b1; c.exp.b_src = 1'b1;
                c.exp.cont = {2'b11, op}; c.exp.rw = 1'b1; plan.push_back(c);
            end
            K_LOAD, K_STORE: begin
                for (int i = 0; i <= mwait; i++) begin
                    rnd(c); c.mr = (i == mwait); c.exp.mreq = 1'b1; c.exp.mds = 1'b1;
                    c.exp.mwe = (k == K_STORE); plan.push_back(c);
                end
                if (k == K_LOAD) begin
                    rnd(c); c.exp.rw = 1'b1; c.exp.rws = 2'd1; plan.push_back(c);
                end
            end
            K_JAL: begin
                rnd(c); c.exp.rw = 1'b1; c.exp.rws = 2'd2; plan.push_back(c);
            end
            default: ;
        endcase
        rnd(c);
        c.hr = (nhalt > 0);
        c.exp.pce = 1'b1;
        case (k)
            K_JAL:   c.exp.pcs = 2'd1;
            K_JCOND: c.exp.pcs = taken ? 2'd1 : 2'd2;
            K_BR: begin
                c.exp.b_src = 1'b1; c.exp.cont = {2'b11, op};
                c.exp.pcs = taken ? 2'd0 : 2'd2;
            end
            default: c.exp.pcs = 2'd2;
        endcase
        plan.push_back(c);
        if (nhalt > 0) begin
            for (int i = 0; i < nhalt; i++) begin
                rnd(c); c.hr = 1'b1; c.exp.hlt = 1'b1; plan.push_back(c);
            end
            rnd(c); c.hr = 1'b0; c.exp.hlt = 1'b1; plan.push_back(c);
        end
    endfunction

    task automatic apply_cycle(input cyc_t c, output out_t obs);
        @(negedge clk);
        reset = c.rst; run = c.run; mem_ready = c.mr; halt_req = c.hr;
        op_code = c.op; ext_op_code = c.ext; A_index = c.aidx; psr_flags = c.psr;
        #1;
        obs = {alu_A_src, alu_B_src, alu_cont, reg_write, reg_write_src, pc_src, pc_en,
               instruction_en, mem_req, mem_we, mem_data_sel, halted, fault};
    endtask

    task automatic step_to(input logic r, input logic rn, input logic mr);
        @(negedge clk);
        rst_to = r; run_to = rn; mr_to = mr;
        #1;
        obs_to = {a_src_t, b_src_t, cont_t, rw_t, rws_t, pcs_t, pce_t, ien_t,
                  mreq_t, mwe_t, mds_t, hlt_t, flt_t};
    endtask

    task automatic test_reset();
        cyc_t c;
        out_t obs, e;
        c = '0; c.run = 1'b1; c.mr = 1'b1; c.psr = 16'($urandom);
        for (int i = 0; i < 2; i++) begin
            apply_cycle(c, obs);
            n_checks++;
            if (obs !== out_t'('0)) begin
                n_fail++; $display("FAIL reset_outputs cycle %0d: got %05h expected 00000", i, obs);
            end
        end
        c.rst = 1'b1; c.mr = 1'b0;
        apply_cycle(c, obs);
        e = '0; e.mreq = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL reset_fetch: got %05h expected %05h", obs, e);
        end
    endtask

    task automatic test_alu_basic();
        cyc_t c;
        out_t obs;
        int   i;
        c = '0; c.rst = 1'b1; c.run = 1'b1; c.mr = 1'b1;
        c.op = 4'b0000; c.ext = 4'b0101; c.aidx = 4'($urandom); c.psr = 16'($urandom);
        c.exp = '0; c.exp.mreq = 1'b1; plan.push_back(c);
        c.exp = '0; c.exp.ien = 1'b1; plan.push_back(c);
        c.exp = '0; plan.push_back(c);
        c.exp = '0; c.exp.a_src = 1'b1; c.exp.cont = 6'b000101; c.exp.rw = 1'b1; plan.push_back(c);
        c.exp = '0; c.exp.pce = 1'b1; c.exp.pcs = 2'd2; plan.push_back(c);
        i = 0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            apply_cycle(c, obs);
            n_checks++;
            if (obs !== c.exp) begin
                n_fail++; $display("FAIL alu_basic cycle %0d: got %05h expected %05h", i, obs, c.exp);
            end
            i++;
        end
    endtask

    task automatic test_directed();
        cyc_t c;
        out_t obs;
        int   i;
        add_instr(4'b0100, 4'b0000, 4'($urandom), 16'($urandom), 0, 0, 3, 0);
        add_instr(4'b1100, 4'($urandom), 4'd0, 16'h0040, 0, 0, 0, 0);
        add_instr(4'b1100, 4'($urandom), 4'd0, 16'hffbf, 0, 0, 0, 0);
        add_instr(4'b0100, 4'b1100, 4'd15, 16'($urandom), 0, 0, 0, 0);
        add_instr(4'b0100, 4'b1100, 4'd14, 16'($urandom), 0, 0, 0, 0);
        add_instr(4'b1011, 4'($urandom), 4'($urandom), 16'($urandom), 0, 0, 0, 3);
        add_instr(4'b0100, 4'b0100, 4'($urandom), 16'($urandom), 0, 14, 14, 0);
        add_instr(4'b0000, 4'b0000, 4'($urandom), 16'($urandom), 4, 1, 0, 0);
        i = 0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            apply_cycle(c, obs);
            n_checks++;
            if (obs !== c.exp) begin
                n_fail++; $display("FAIL directed cycle %0d: got %05h expected %05h", i, obs, c.exp);
            end
            i++;
        end
    endtask

    task automatic test_random();
        cyc_t        c;
        out_t        obs;
        int          i, fw, mw, nr, nh;
        logic [3:0]  op, ext;
        for (int n = 0; n < 40; n++) begin
            op  = 4'($urandom);
            ext = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3) << 2) : 4'($urandom);
            fw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
            mw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
            nr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            nh  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            add_instr(op, ext, 4'($urandom), 16'($urandom), nr, fw, mw, nh);
        end
        i = 0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            apply_cycle(c, obs);
            n_checks++;
            if (obs !== c.exp) begin
                n_fail++; $display("FAIL random cycle %0d op %h ext %h: got %05h expected %05h",
                                   i, c.op, c.ext, obs, c.exp);
            end
            i++;
        end
    endtask

    task automatic test_reset_midwait();
        cyc_t c;
        out_t obs;
        int   i;
        add_instr(4'b0100, 4'b0000, 4'($urandom), 16'($urandom), 0, 0, 6, 0);
        while (plan.size() > 6) void'(plan.pop_back());
        c = plan[5];
        c.rst = 1'b0; c.exp = '0; plan.push_back(c);
        c.mr = 1'b1; plan.push_back(c);
        add_instr(4'b1111, 4'($urandom), 4'($urandom), 16'($urandom), 0, 1, 0, 0);
        i = 0;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            apply_cycle(c, obs);
            n_checks++;
            if (obs !== c.exp) begin
                n_fail++; $display("FAIL reset_midwait cycle %0d: got %05h expected %05h", i, obs, c.exp);
            end
            i++;
        end
    endtask

    task automatic test_timeout();
        out_t e;
        for (int i = 0; i < 3; i++) begin
            step_to(1'b1, 1'b1, 1'b0);
            e = '0; e.mreq = 1'b1;
            n_checks++;
            if (obs_to !== e) begin
                n_fail++; $display("FAIL timeout_wait cycle %0d: got %05h expected %05h", i, obs_to, e);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step_to(1'b1, 1'b1, 1'($urandom));
            e = '0; e.flt = 1'b1;
            n_checks++;
            if (obs_to !== e) begin
                n_fail++; $display("FAIL timeout_fault cycle %0d: got %05h expected %05h", i, obs_to, e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step_to(1'b0, 1'b1, 1'b1);
            n_checks++;
            if (obs_to !== out_t'('0)) begin
                n_fail++; $display("FAIL timeout_reset cycle %0d: got %05h expected 00000", i, obs_to);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step_to(1'b1, 1'b1, i == 2);
            e = '0; e.mreq = 1'b1;
            n_checks++;
            if (obs_to !== e) begin
                n_fail++; $display("FAIL ready_wins_fetch cycle %0d: got %05h expected %05h", i, obs_to, e);
            end
        end
        step_to(1'b1, 1'b1, 1'b0);
        e = '0; e.ien = 1'b1;
        n_checks++;
        if (obs_to !== e) begin
            n_fail++; $display("FAIL ready_wins_decode: got %05h expected %05h", obs_to, e);
        end
        step_to(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_run_hold();
        out_t e;
        step_to(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step_to(1'b1, 1'b0, 1'($urandom));
            n_checks++;
            if (obs_to !== out_t'('0)) begin
                n_fail++; $display("FAIL run_hold cycle %0d: got %05h expected 00000", i, obs_to);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step_to(1'b1, 1'b1, i == 2);
            e = '0; e.mreq = 1'b1;
            n_checks++;
            if (obs_to !== e) begin
                n_fail++; $display("FAIL run_resume cycle %0d: got %05h expected %05h", i, obs_to, e);
            end
        end
        step_to(1'b1, 1'b1, 1'b0);
        e = '0; e.ien = 1'b1;
        n_checks++;
        if (obs_to !== e) begin
            n_fail++; $display("FAIL run_resume_decode: got %05h expected %05h", obs_to, e);
        end
        step_to(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_directed();
        test_random();
        test_reset_midwait();
        @(negedge clk);
        reset = 1'b0;
        test_timeout();
        test_run_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
